online_otf_converter: RTL and testbench

Downstream stage of the radix-2 online serial adder. Consumes the adder's most-significant-digit-first signed-digit output stream, discards the online-delay lead-in digits, and converts the remaining digits on the fly into a conventional two's-complement word. No carry-propagate addition is needed. The result is available one cycle after the last digit is accepted.

---
 rtl/online_pkg.sv | 30 +++
 rtl/online_otf_step.sv | 43 ++++
 rtl/online_otf_converter.sv | 101 ++++++++++
 tb/tb_online_otf_converter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/online_pkg.sv
// Shared definitions for the radix-2 online adder and its on-the-fly converter:
// signed-digit encoding, converter state type and digit decode.
package online_pkg;

    localparam logic [1:0] DIG_POS = 2'b10;
    localparam logic [1:0] DIG_NEG = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        CONV,
        DONE
    } state_t;

    // Both 00 and 11 mean zero; 11 is a legal redundant encoding, not an error.
    function automatic logic signed [1:0] digit_value(input logic [1:0] digit);
        logic signed [1:0] v;
        case (digit)
            DIG_POS: v = 2'sd1;
            DIG_NEG: v = -2'sd1;
            default: v = 2'sd0;
        endcase
        return v;
    endfunction

    function automatic int unsigned max_uint(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/online_otf_step.sv
// One on-the-fly conversion step: shifts Q/QM left and appends a bit, keeping QM = Q - 1.
// Pure selection between the two registers, so no carry chain is needed.
module online_otf_step
    import online_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] i_q,
    input  logic [W-1:0] i_qm,
    input  logic [1:0]   i_digit,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_qm
);

    logic signed [1:0] w_d;
    logic [W-1:0]      w_q_sh;
    logic [W-1:0]      w_qm_sh;

    assign w_d     = digit_value(i_digit);
    // The shift drops the MSB; the result range guarantees it carries no information.
    assign w_q_sh  = i_q << 1;
    assign w_qm_sh = i_qm << 1;

    always_comb begin
        o_q  = w_q_sh;
        o_qm = w_qm_sh | W'(1);
        case (w_d)
            2'sd1: begin
                o_q  = w_q_sh | W'(1);
                o_qm = w_q_sh;
            end
            -2'sd1: begin
                o_q  = w_qm_sh | W'(1);
                o_qm = w_qm_sh;
            end
            default: begin
                o_q  = w_q_sh;
                o_qm = w_qm_sh | W'(1);
            end
        endcase
    end

endmodule

// File: rtl/online_otf_converter.sv
// Drops the online-delay lead-in digits of an MSD-first signed-digit stream and converts
// the remaining DIGITS digits on the fly into a two's-complement word.
module online_otf_converter
    import online_pkg::*;
#(
    parameter int unsigned DIGITS       = 64,
    parameter int unsigned ONLINE_DELAY = 3
) (
    input  logic              clk,
    input  logic              asyn_reset,
    input  logic              start,
    input  logic [1:0]        digit_in,
    input  logic              digit_valid,
    output logic [DIGITS:0]   result,
    output logic              result_valid,
    output logic              busy
);

    localparam int unsigned W     = DIGITS + 1;
    localparam int unsigned CNT_W = $clog2(max_uint(DIGITS, ONLINE_DELAY) + 1);
    localparam state_t      START_ST = (ONLINE_DELAY == 0) ? CONV : SKIP;
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(ONLINE_DELAY - 1);
    localparam logic [CNT_W-1:0] DIG_LAST  = CNT_W'(DIGITS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_skip_cnt;
    logic [CNT_W-1:0] r_dig_cnt;
    logic [W-1:0]     r_q;
    logic [W-1:0]     r_qm;
    logic [W-1:0]     r_result;
    logic             r_result_valid;
    logic             r_busy;

    logic [W-1:0]     w_q_next;
    logic [W-1:0]     w_qm_next;

    online_otf_step #(
        .W (W)
    ) u_step (
        .i_q     (r_q),
        .i_qm    (r_qm),
        .i_digit (digit_in),
        .o_q     (w_q_next),
        .o_qm    (w_qm_next)
    );

    // start has priority over any digit presented in the same cycle.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            r_state        <= IDLE;
            r_skip_cnt     <= '0;
            r_dig_cnt      <= '0;
            r_q            <= '0;
            r_qm           <= '1;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else if (start) begin
            r_state        <= START_ST;
            r_skip_cnt     <= '0;
            r_dig_cnt      <= '0;
            r_q            <= '0;
            r_qm           <= '1;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b1;
        end else begin
            case (r_state)
                SKIP: begin
                    if (digit_valid) begin
                        r_skip_cnt <= r_skip_cnt + CNT_W'(1);
                        if (r_skip_cnt == SKIP_LAST) begin
                            r_state <= CONV;
                        end
                    end
                end
                CONV: begin
                    if (digit_valid) begin
                        r_q       <= w_q_next;
                        r_qm      <= w_qm_next;
                        r_dig_cnt <= r_dig_cnt + CNT_W'(1);
                        if (r_dig_cnt == DIG_LAST) begin
                            r_state        <= DONE;
                            r_result       <= w_q_next;
                            r_result_valid <= 1'b1;
                            r_busy         <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;

endmodule

// File: tb/tb_online_otf_converter.sv
// Randomized scoreboard bench for online_otf_converter with DIGITS = 4, ONLINE_DELAY = 3.
module tb_online_otf_converter;

    localparam int DIGITS = 4;
    localparam int OD     = 3;

    logic              clk;
    logic              asyn_reset;
    logic              start;
    logic [1:0]        digit_in;
    logic              digit_valid;
    logic [DIGITS:0]   result;
    logic              result_valid;
    logic              busy;

    online_otf_converter #(
        .DIGITS       (DIGITS),
        .ONLINE_DELAY (OD)
    ) dut (
        .clk          (clk),
        .asyn_reset   (asyn_reset),
        .start        (start),
        .digit_in     (digit_in),
        .digit_valid  (digit_valid),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    typedef struct {
        int val;
        int edge_n;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_total  = 0;
    int   n_pass   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [1:0] enc(input int v);
        if (v > 0) return 2'b10;
        if (v < 0) return 2'b01;
        return ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    endfunction

    function automatic int ref_value(input int v[DIGITS]);
        int acc = 0;
        for (int i = 0; i < DIGITS; i++) acc += v[i] * (1 << (DIGITS - 1 - i));
        return acc;
    endfunction

    function automatic int res_int();
        return int'($signed(result));
    endfunction

    task automatic drive(input bit s, input bit dv, input logic [1:0] d);
        start       = s;
        digit_valid = dv;
        digit_in    = d;
        @(posedge clk);
        #1;
        start       = 1'b0;
        digit_valid = 1'b0;
        digit_in    = 2'($urandom);
    endtask

    // gap_mode: 0 none, 1 random stalls, 2 exactly two stalls inside the conversion
    task automatic gap(input int gap_mode, input int k, inout int gaps);
        if (gap_mode == 1) begin
            while ($urandom_range(0, 99) < 30) begin
                drive(1'b0, 1'b0, 2'($urandom));
                gaps++;
            end
        end else if (gap_mode == 2 && k >= OD && (k == OD + 1 || k == OD + 3)) begin
            drive(1'b0, 1'b0, 2'($urandom));
            gaps++;
        end
    endtask

    task automatic run_op(input int v[DIGITS], input int gap_mode, input bit start_dv);
        int   start_edge;
        int   gaps = 0;
        int   expv;
        exp_t e;
        expv = ref_value(v);
        drive(1'b1, start_dv, 2'b10);
        start_edge = edge_cnt;
        check("busy_after_start", busy == 1'b1, busy, 1);
        check("rv_after_start", result_valid == 1'b0, result_valid, 0);
        for (int k = 0; k < OD + DIGITS; k++) begin
            gap(gap_mode, k, gaps);
            if (k == OD + DIGITS - 1) begin
                e.val    = expv;
                e.edge_n = start_edge + OD + DIGITS + gaps;
                sb.push_back(e);
            end
            drive(1'b0, 1'b1, (k < OD) ? 2'($urandom) : enc(v[k - OD]));
        end
        check("busy_after_last", busy == 1'b0, busy, 0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'($urandom), 2'($urandom));
        check("rv_hold", result_valid == 1'b1, result_valid, 1);
        check("result_hold", res_int() == expv, res_int(), expv);
    endtask

    task automatic pulse_reset();
        #2;
        asyn_reset = 1'b1;
        #1;
        check("reset_result", result == '0, result, 0);
        check("reset_rv", result_valid == 1'b0, result_valid, 0);
        check("reset_busy", busy == 1'b0, busy, 0);
        @(negedge clk);
        asyn_reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: on each rising result_valid, pop and compare value and arrival edge.
    initial begin
        bit   prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (asyn_reset) begin
                prev = 1'b0;
            end else begin
                if (result_valid && !prev) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 1'b0, res_int(), 0);
                    end else begin
                        e = sb.pop_front();
                        check("result_value", res_int() == e.val, res_int(), e.val);
                        check("result_edge", edge_cnt == e.edge_n, edge_cnt, e.edge_n);
                    end
                end
                prev = result_valid;
            end
        end
    end

    initial begin
        int v[DIGITS];
        asyn_reset  = 1'b1;
        start       = 1'b0;
        digit_valid = 1'b0;
        digit_in    = 2'b00;
        #12;
        check("init_result", result == '0, result, 0);
        check("init_rv", result_valid == 1'b0, result_valid, 0);
        check("init_busy", busy == 1'b0, busy, 0);
        asyn_reset = 1'b0;
        @(posedge clk);
        #1;

        run_op('{1, 0, -1, 1}, 0, 1'b0);
        pulse_reset();

        run_op('{-1, -1, -1, -1}, 0, 1'b0);
        run_op('{1, 1, 1, 1}, 0, 1'b0);
        run_op('{0, 0, 1, 0}, 2, 1'b0);

        // Aborted run: no result may appear; the restart carries a discarded digit.
        drive(1'b1, 1'b0, 2'b00);
        for (int k = 0; k < OD + 2; k++) drive(1'b0, 1'b1, 2'b10);
        run_op('{1, -1, 0, 0}, 0, 1'b1);

        // Reset during conversion, then digits with no start must do nothing.
        drive(1'b1, 1'b0, 2'b00);
        for (int k = 0; k < OD + 2; k++) drive(1'b0, 1'b1, 2'b01);
        pulse_reset();
        for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, 2'b10);
        check("idle_rv", result_valid == 1'b0, result_valid, 0);
        check("idle_busy", busy == 1'b0, busy, 0);
        check("idle_result", result == '0, result, 0);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < DIGITS; i++) v[i] = int'($urandom_range(0, 2)) - 1;
            run_op(v, int'($urandom_range(0, 1)), 1'($urandom));
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) drive(1'b0, 1'b0, 2'b00);
        check("scoreboard_drained", sb.size() == 0, sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
